// File: rtl/loader_pkg.sv
// Shared definitions for the boot-image memory loader: FSM state codes,
// frame field geometry and the write-address helper.
package loader_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_COUNT = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  // Every multi-byte frame field (address, count, data word) is this many bytes.
  localparam int FIELD_BYTES = 4;
  localparam logic [31:0] ADDR_STEP = 32'd4;

  // Byte address of word idx; wraps modulo 2^32 by construction.
  function automatic logic [31:0] wordAddr(input logic [31:0] base, input logic [31:0] idx);
    return base + idx * ADDR_STEP;
  endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Byte-stream input and CPU-side memory/reset outputs of the loader.
// slave: the loader itself; master: whatever feeds bytes and watches the bus.
interface mem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        Ext_MemWrite;
  logic [31:0] Ext_WriteData;
  logic [31:0] Ext_DataAdr;
  logic        cpu_reset;
  logic        done;
  logic        error;

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, Ext_MemWrite, Ext_WriteData, Ext_DataAdr, cpu_reset, done, error
  );

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, Ext_MemWrite, Ext_WriteData, Ext_DataAdr, cpu_reset, done, error
  );
endinterface

// File: rtl/byte_assembler.sv
// Little-endian 4-byte shift register with byte counter; flags the byte that
// completes a field and presents the full field value in that same cycle.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shiftEn,
  input  logic [7:0]  rxByte,
  output logic [31:0] word,
  output logic        wordDone
);

  localparam int CNT_W = $clog2(FIELD_BYTES);

  logic [31:0]      shiftReg;
  logic [CNT_W-1:0] byteCnt;

  // Newest byte enters at the top, so the first byte of a field ends in [7:0].
  assign word     = {rxByte, shiftReg[31:8]};
  assign wordDone = shiftEn && (byteCnt == CNT_W'(FIELD_BYTES - 1));

  // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shiftReg <= '0;
      byteCnt  <= '0;
    end else if (clear) begin
      shiftReg <= '0;
      byteCnt  <= '0;
    end else if (shiftEn) begin
      shiftReg <= word;
      byteCnt  <= byteCnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Receives a framed byte stream (sync, base, count, words) and writes the words
// into CPU data memory, holding the CPU in reset until the image is complete.
module mem_loader
  import loader_pkg::*;
#(
  parameter int         MAX_WORDS = 256,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic          clk,
  input logic          reset,
  mem_loader_if.slave  bus
);

  logic [2:0]  state;
  logic [31:0] baseAdr;
  logic [31:0] wordCount;
  logic [31:0] wordIdx;
  logic [31:0] writeData;
  logic [31:0] dataAdr;

  logic        accept;
  logic        inField;
  logic        syncHit;
  logic [31:0] asmWord;
  logic        asmDone;
  logic        countOk;

  assign accept  = bus.rx_valid && bus.rx_ready;
  assign inField = (state == S_ADDR) || (state == S_COUNT) || (state == S_DATA);
  // Sync only counts between frames; inside a frame it is plain payload.
  assign syncHit = accept && (bus.rx_data == SYNC_BYTE) &&
                   ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign countOk = (asmWord != 32'd0) && (asmWord <= 32'(MAX_WORDS));

  byte_assembler u_asm (
    .clk      (clk),
    .reset    (reset),
    .clear    (syncHit),
    .shiftEn  (accept && inField),
    .rxByte   (bus.rx_data),
    .word     (asmWord),
    .wordDone (asmDone)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      baseAdr   <= '0;
      wordCount <= '0;
      wordIdx   <= '0;
      writeData <= '0;
      dataAdr   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (syncHit) begin
            state   <= S_ADDR;
            wordIdx <= '0;
          end
        end
        S_ADDR: begin
          if (asmDone) begin
            baseAdr <= asmWord;
            state   <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (asmDone) begin
            wordCount <= asmWord;
            state     <= countOk ? S_DATA : S_ERROR;
          end
        end
        S_DATA: begin
          if (asmDone) begin
            writeData <= asmWord;
            dataAdr   <= wordAddr(baseAdr, wordIdx);
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          wordIdx <= wordIdx + 32'd1;
          state   <= (wordIdx + 32'd1 < wordCount) ? S_DATA : S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: outputs decode from the registered state through continuous assigns, so
  // no latch can form and they follow reset immediately.
  assign bus.rx_ready      = (state != S_WRITE);
  assign bus.Ext_MemWrite  = (state == S_WRITE);
  assign bus.Ext_WriteData = writeData;
  assign bus.Ext_DataAdr   = dataAdr;
  assign bus.cpu_reset     = (state != S_DONE);
  assign bus.done          = (state == S_DONE);
  assign bus.error         = (state == S_ERROR);

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: table-driven frames, hand-written corner
// sequences and randomized frames checked against an expected-write model.
module tb_mem_loader;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         MAXW = 256;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    string       name;
    logic [31:0] base;
    logic [31:0] count;
    logic [31:0] seed;
    logic [31:0] step;
    logic [31:0] lastAdr;
    int          nWrites;
    bit          expDone;
    bit          expErr;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  mem_loader_if bus ();

  mem_loader #(.MAX_WORDS(MAXW), .SYNC_BYTE(SYNC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int  nChecks = 0;
  int  nFails  = 0;
  int  readyLow = 0;
  int  readyErr = 0;
  wr_t seenWrites[$];
  wr_t expQ[$];
  vec_t vecs[8];

  // Monitor: every strobe cycle is one observed write; rx_ready must be its inverse.
  always @(negedge clk) begin
    wr_t w;
    if (bus.Ext_MemWrite === 1'b1) begin
      w.adr  = bus.Ext_DataAdr;
      w.data = bus.Ext_WriteData;
      seenWrites.push_back(w);
    end
    if (bus.rx_ready === bus.Ext_MemWrite) readyErr++;
    if (bus.rx_ready !== 1'b1) readyLow++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic sendByte(input logic [7:0] b, input bit gaps);
    int guard = 0;
    if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (bus.rx_ready !== 1'b1) begin
      nChecks++;
      nFails++;
      $display("FAIL rx_ready timeout: byte 0x%02h never accepted", b);
    end
    @(negedge clk);
  endtask

  task automatic send32(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) sendByte(w[8*i +: 8], gaps);
  endtask

  task automatic pushExp(input logic [31:0] adr, input logic [31:0] data);
    wr_t w;
    w.adr  = adr;
    w.data = data;
    expQ.push_back(w);
  endtask

  task automatic compareWrites(input string tag, input int wrBase);
    int got = seenWrites.size() - wrBase;
    check({tag, " write count"}, 32'(got), 32'(expQ.size()));
    for (int k = 0; k < expQ.size() && k < got; k++) begin
      check($sformatf("%s wr%0d adr", tag, k), seenWrites[wrBase + k].adr, expQ[k].adr);
      check($sformatf("%s wr%0d data", tag, k), seenWrites[wrBase + k].data, expQ[k].data);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, " rx_ready"},      bus.rx_ready,      32'd1);
    check({tag, " Ext_MemWrite"},  bus.Ext_MemWrite,  32'd0);
    check({tag, " Ext_WriteData"}, bus.Ext_WriteData, 32'd0);
    check({tag, " Ext_DataAdr"},   bus.Ext_DataAdr,   32'd0);
    check({tag, " cpu_reset"},     bus.cpu_reset,     32'd1);
    check({tag, " done"},          bus.done,          32'd0);
    check({tag, " error"},         bus.error,         32'd0);
  endtask

  initial begin
    int          wrBase;
    int          rlBase;
    logic [31:0] base;
    logic [31:0] cnt;
    logic [31:0] w;
    logic [7:0]  junk;
    bit          ok;

    vecs[0] = '{"req034",  32'h0000_0100, 32'd2,          32'h0050_0013, 32'h0050_0080, 32'h0000_0104, 2,   1'b1, 1'b0};
    vecs[1] = '{"wrap",    32'hFFFF_FFFC, 32'd2,          32'hDEAD_BEEF, 32'h0101_0101, 32'h0000_0000, 2,   1'b1, 1'b0};
    vecs[2] = '{"cnt0",    32'h0000_0040, 32'd0,          32'h0,         32'h0,         32'h0,         0,   1'b0, 1'b1};
    vecs[3] = '{"cnt101",  32'h0000_0040, 32'h0000_0101,  32'h0,         32'h0,         32'h0,         0,   1'b0, 1'b1};
    vecs[4] = '{"cnt1",    32'h0000_2000, 32'd1,          32'h1234_5678, 32'h0,         32'h0000_2000, 1,   1'b1, 1'b0};
    vecs[5] = '{"cntHuge", 32'h0000_0000, 32'h8000_0001,  32'h0,         32'h0,         32'h0,         0,   1'b0, 1'b1};
    vecs[6] = '{"syncPay", 32'hA5A5_A5A5, 32'd1,          32'hA5A5_A5A5, 32'h0,         32'hA5A5_A5A5, 1,   1'b1, 1'b0};
    vecs[7] = '{"cntMax",  32'h0000_F000, 32'd256,        32'h0000_0000, 32'h0000_0004, 32'h0000_F3FC, 256, 1'b1, 1'b0};

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset        = 1'b0;
    repeat (2) @(negedge clk);
    checkResetOutputs("por");
    reset = 1'b1;
    @(negedge clk);

    // Junk before sync in IDLE is dropped; a misread would misalign the frame.
    wrBase = seenWrites.size();
    sendByte(8'h00, 1'b0);
    sendByte(8'hFF, 1'b0);
    idle(1);
    check("idle junk done",  bus.done,  32'd0);
    check("idle junk error", bus.error, 32'd0);
    expQ.delete();
    pushExp(32'h40, 32'h0BAD_F00D);
    sendByte(SYNC, 1'b0);
    send32(32'h40, 1'b0);
    send32(32'd1, 1'b0);
    send32(32'h0BAD_F00D, 1'b0);
    idle(2);
    compareWrites("idle junk", wrBase);
    check("idle junk done after frame", bus.done, 32'd1);

    // Table of frames, streamed with rx_valid held high throughout.
    for (int v = 0; v < 8; v++) begin
      wrBase = seenWrites.size();
      rlBase = readyLow;
      expQ.delete();
      for (int k = 0; k < vecs[v].nWrites; k++)
        pushExp(vecs[v].base + 32'(k) * 32'd4, vecs[v].seed + 32'(k) * vecs[v].step);
      sendByte(SYNC, 1'b0);
      send32(vecs[v].base, 1'b0);
      send32(vecs[v].count, 1'b0);
      for (int k = 0; k < vecs[v].nWrites; k++)
        send32(vecs[v].seed + 32'(k) * vecs[v].step, 1'b0);
      idle(2);
      check({vecs[v].name, " done"},      bus.done,      32'(vecs[v].expDone));
      check({vecs[v].name, " error"},     bus.error,     32'(vecs[v].expErr));
      check({vecs[v].name, " cpu_reset"}, bus.cpu_reset, 32'(!vecs[v].expDone));
      check({vecs[v].name, " ready-low cycles"}, 32'(readyLow - rlBase), 32'(vecs[v].nWrites));
      compareWrites(vecs[v].name, wrBase);
      if (vecs[v].nWrites > 0 && seenWrites.size() > wrBase)
        check({vecs[v].name, " last adr"}, seenWrites[seenWrites.size() - 1].adr, vecs[v].lastAdr);
    end

    // Exact timing around the final write and DONE entry.
    sendByte(SYNC, 1'b0);
    send32(32'h100, 1'b0);
    send32(32'd2, 1'b0);
    send32(32'h0050_0013, 1'b0);
    sendByte(8'h93, 1'b0);
    sendByte(8'h00, 1'b0);
    sendByte(8'hA0, 1'b0);
    sendByte(8'h00, 1'b0);
    check("last write strobe",    bus.Ext_MemWrite,  32'd1);
    check("last write adr",       bus.Ext_DataAdr,   32'h104);
    check("last write data",      bus.Ext_WriteData, 32'h00A0_0093);
    check("last write rx_ready",  bus.rx_ready,      32'd0);
    check("last write cpu_reset", bus.cpu_reset,     32'd1);
    check("last write done",      bus.done,          32'd0);
    idle(1);
    check("done entry done",      bus.done,          32'd1);
    check("done entry cpu_reset", bus.cpu_reset,     32'd0);
    check("done entry strobe",    bus.Ext_MemWrite,  32'd0);
    check("done entry adr hold",  bus.Ext_DataAdr,   32'h104);
    check("done entry data hold", bus.Ext_WriteData, 32'h00A0_0093);
    sendByte(8'h3C, 1'b0);
    idle(1);
    check("done ignores junk", bus.done, 32'd1);

    // Reset mid-frame, asserted between clock edges, then a fresh frame.
    wrBase = seenWrites.size();
    sendByte(SYNC, 1'b0);
    send32(32'h500, 1'b0);
    send32(32'd2, 1'b0);
    sendByte(8'h11, 1'b0);
    sendByte(8'h22, 1'b0);
    #2 reset = 1'b0;
    #1 checkResetOutputs("midframe reset");
    idle(2);
    reset = 1'b1;
    idle(1);
    check("no write from aborted frame", 32'(seenWrites.size() - wrBase), 32'd0);
    expQ.delete();
    pushExp(32'h600, 32'hCAFE_F00D);
    sendByte(SYNC, 1'b0);
    send32(32'h600, 1'b0);
    send32(32'd1, 1'b0);
    send32(32'hCAFE_F00D, 1'b0);
    idle(2);
    compareWrites("after reset", wrBase);
    check("after reset done", bus.done, 32'd1);

    // Randomized frames with stalls, junk prefixes and sync-valued payload bytes.
    for (int it = 0; it < 24; it++) begin
      base = $urandom;
      if ($urandom_range(0, 4) == 0)
        cnt = ($urandom_range(0, 1) == 1) ? 32'd0 : 32'd257 + 32'($urandom_range(0, 5000));
      else
        cnt = 32'($urandom_range(1, 6));
      ok = (cnt >= 32'd1) && (cnt <= 32'(MAXW));
      wrBase = seenWrites.size();
      rlBase = readyLow;
      expQ.delete();
      repeat ($urandom_range(0, 3)) begin
        junk = 8'($urandom);
        if (junk == SYNC) junk = 8'h5A;
        sendByte(junk, 1'b1);
      end
      sendByte(SYNC, 1'b1);
      send32(base, 1'b1);
      send32(cnt, 1'b1);
      if (ok) begin
        for (int k = 0; k < int'(cnt); k++) begin
          w = $urandom;
          if ($urandom_range(0, 3) == 0) w[15:8] = SYNC;
          pushExp(base + 32'(k) * 32'd4, w);
          send32(w, 1'b1);
        end
      end
      idle(2);
      check($sformatf("rnd%0d done", it),      bus.done,      32'(ok));
      check($sformatf("rnd%0d error", it),     bus.error,     32'(!ok));
      check($sformatf("rnd%0d cpu_reset", it), bus.cpu_reset, 32'(!ok));
      check($sformatf("rnd%0d ready-low cycles", it), 32'(readyLow - rlBase), 32'(expQ.size()));
      compareWrites($sformatf("rnd%0d", it), wrBase);
    end

    check("rx_ready low only on write cycles", 32'(readyErr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 The block SHALL have parameter MAX_WORDS, default 256: largest word count accepted per load.
REQ-002 The block SHALL have parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-003 The block SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port rx_valid  input  1  incoming byte valid.
REQ-006 The block SHALL have port rx_data  input  8  incoming byte.
REQ-007 The block SHALL have port rx_ready  output  1  byte accepted when rx_valid and rx_ready are both high on a clk edge.
REQ-008 The block SHALL have port Ext_MemWrite  output  1  external data-memory write strobe to the CPU top.
REQ-009 The block SHALL have port Ext_WriteData  output  32  word to write.
REQ-010 The block SHALL have port Ext_DataAdr  output  32  byte address of the write.
REQ-011 The block SHALL have port cpu_reset  output  1  active-high hold driven to the CPU top reset input.
REQ-012 The block SHALL have port done  output  1  high once a frame is completely written.
REQ-013 The block SHALL have port error  output  1  high after a rejected frame header.

Function
REQ-014 Frame format SHALL be: SYNC_BYTE; 4-byte base address; 4-byte word count N; N 4-byte data words. All multi-byte fields are little-endian.
REQ-015 The FSM SHALL have states IDLE, ADDR, COUNT, DATA, WRITE, DONE, ERROR.
REQ-016 In IDLE, DONE and ERROR, accepted bytes not equal to SYNC_BYTE SHALL be consumed and ignored.
REQ-017 An accepted SYNC_BYTE in IDLE, DONE or ERROR SHALL enter ADDR, clear done and error, and assert cpu_reset.
REQ-018 ADDR SHALL move to COUNT after 4 accepted bytes.
REQ-019 COUNT SHALL move to DATA after 4 bytes if 1 <= N <= MAX_WORDS; otherwise it SHALL move to ERROR.
REQ-020 DATA SHALL enter WRITE after the 4th byte of a word is accepted.
REQ-021 WRITE SHALL last exactly one cycle, during which Ext_MemWrite=1, Ext_WriteData is the assembled word, and Ext_DataAdr = base + 4*k, where k is the 0-based word index.
REQ-022 Address arithmetic SHALL be 32-bit modulo 2^32 (wrap allowed, no error).
REQ-023 WRITE SHALL return to DATA if k+1 < N, else enter DONE.
REQ-024 rx_ready SHALL be 0 in WRITE and 1 in every other state.
REQ-025 Ext_MemWrite SHALL be 0 in every state except WRITE; Ext_DataAdr and Ext_WriteData hold their last value otherwise.
REQ-026 cpu_reset SHALL be 1 in all states except DONE; it SHALL deassert on the cycle DONE is entered, so the CPU starts from a fully written memory.
REQ-027 done SHALL be 1 only in DONE; error SHALL be 1 only in ERROR.
REQ-028 A SYNC_BYTE seen in ADDR, COUNT or DATA SHALL be treated as ordinary payload; there is no mid-frame resync.
REQ-029 There SHALL be no timeout; a stalled stream holds the current state indefinitely.

Reset
REQ-030 While reset=0, the block SHALL be asynchronously forced to IDLE with rx_ready=1, Ext_MemWrite=0, Ext_WriteData=0, Ext_DataAdr=0, cpu_reset=1, done=0, error=0, and all byte and word counters and assembly registers at 0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame; no write strobe SHALL be produced during or after it.

Structure
REQ-032 FSM state encodings, the frame field byte counts (4), and the address step (4) SHALL live in a shared package, loader_pkg.
REQ-033 One sub-module SHALL be used: byte_assembler (4-byte little-endian shift register with byte counter and word-complete flag), instantiated once and reused for the address, count and data fields.

Verification
REQ-034 Scenario: A5, 00 01 00 00, 02 00 00 00, 13 00 50 00, 93 00 A0 00 -> writes 0x00500013 @0x100 then 0x00A00093 @0x104; done=1 and cpu_reset=0 in the cycle after the 2nd write.
REQ-035 Scenario: count field 00 00 00 00, then a second frame with count 0x101 -> error=1 each time, no Ext_MemWrite pulse, cpu_reset stays 1.
REQ-036 Scenario: bytes 00 FF then A5 in IDLE -> the first two are ignored and the FSM enters ADDR on A5.
REQ-037 Scenario: base FFFFFFFC, N=2 -> writes at 0xFFFFFFFC then 0x00000000.
REQ-038 Scenario: rx_valid held high continuously -> rx_ready=0 exactly on each WRITE cycle and no byte is lost.
REQ-039 Scenario: reset=0 after the 2nd data byte, then a new frame -> no stale write, and the new frame completes correctly.
